// File: rtl/demux_pkg.sv
// Shared types for the packet-aware 1-to-2 stream demultiplexer.
package demux_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   localparam logic LANE0 = 1'b0;
   localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/demux_1to2_stream_if.sv
// Producer-side and two consumer-side valid/ready streams of the demultiplexer.
interface demux_1to2_stream_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_last;
   logic             din_ready;
   logic             sel;

   logic [WIDTH-1:0] dout0;
   logic             dout0_valid;
   logic             dout0_last;
   logic             dout0_ready;

   logic [WIDTH-1:0] dout1;
   logic             dout1_valid;
   logic             dout1_last;
   logic             dout1_ready;

   modport slave (
      input  din, din_valid, din_last, sel, dout0_ready, dout1_ready,
      output din_ready, dout0, dout0_valid, dout0_last, dout1, dout1_valid, dout1_last
   );

   modport master (
      output din, din_valid, din_last, sel, dout0_ready, dout1_ready,
      input  din_ready, dout0, dout0_valid, dout0_last, dout1, dout1_valid, dout1_last
   );

endinterface

// File: rtl/stream_fifo.sv
// Synchronous FIFO with registered storage; DEPTH must be a power of two.
module stream_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign pop_data = mem_q[rd_ptr_q];
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/demux_1to2_stream.sv
// Packet-aware 1-to-2 stream demux: lane chosen on a packet's first beat and held until last.
module demux_1to2_stream
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   demux_1to2_stream_if.slave        bus,
   output logic                      pkt_active
);

   localparam int unsigned ENTRY_W = WIDTH + 1;

   state_e             state_q, state_d;
   logic               lock_sel_q, lock_sel_d;
   logic               target_c;
   logic               accept_c;
   logic               full0, full1, empty0, empty1;
   logic               push0, push1, pop0, pop1;
   logic [ENTRY_W-1:0] rd0, rd1;

   assign target_c      = (state_q == ST_LOCKED) ? lock_sel_q : bus.sel;
   assign bus.din_ready = rst_n & ~((target_c == LANE1) ? full1 : full0);
   assign accept_c      = bus.din_valid & bus.din_ready;
   assign pkt_active    = (state_q == ST_LOCKED);

   // Lane lock: sel is only looked at while idle.
   always_comb begin
      state_d    = state_q;
      lock_sel_d = lock_sel_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_c && !bus.din_last) begin
               state_d    = ST_LOCKED;
               lock_sel_d = bus.sel;
            end
         end
         ST_LOCKED: begin
            if (accept_c && bus.din_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         lock_sel_q <= LANE0;
      end else begin
         state_q    <= state_d;
         lock_sel_q <= lock_sel_d;
      end
   end

   assign push0 = accept_c & (target_c == LANE0);
   assign push1 = accept_c & (target_c == LANE1);
   assign pop0  = bus.dout0_valid & bus.dout0_ready;
   assign pop1  = bus.dout1_valid & bus.dout1_ready;

   stream_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push0),
      .push_data ({bus.din_last, bus.din}),
      .pop       (pop0),
      .pop_data  (rd0),
      .full      (full0),
      .empty     (empty0)
   );

   stream_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push1),
      .push_data ({bus.din_last, bus.din}),
      .pop       (pop1),
      .pop_data  (rd1),
      .full      (full1),
      .empty     (empty1)
   );

   assign bus.dout0_valid = ~empty0;
   assign bus.dout1_valid = ~empty1;
   assign {bus.dout0_last, bus.dout0} = rd0;
   assign {bus.dout1_last, bus.dout1} = rd1;

endmodule
